// File: rtl/blk_fetch.sv
// blk_fetch: expands block indices into row-major frame-buffer reads and streams the
// returned pixels through a credit-protected FWFT FIFO with start/end-of-block tags.
module blk_fetch #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int BLK_SIZE   = 32,
    parameter int PIX_W      = 8,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int COLUMNS   = IMG_WIDTH / BLK_SIZE,
    localparam int ROWS      = IMG_HEIGHT / BLK_SIZE,
    localparam int NBLK      = COLUMNS * ROWS,
    localparam int BW        = $clog2(NBLK),
    localparam int AW        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_blk_vld,
    input  logic [BW-1:0]    i_blk_adr,
    output logic             o_blk_rdy,
    output logic             o_blk_err,
    output logic             o_mem_rd,
    output logic [AW-1:0]    o_mem_adr,
    input  logic [PIX_W-1:0] i_mem_data,
    output logic             o_pix_vld,
    output logic [PIX_W-1:0] o_pix_data,
    output logic             o_pix_sob,
    output logic             o_pix_eob,
    input  logic             i_pix_rdy
);
    localparam int PW = $clog2(BLK_SIZE);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FETCH = 2'd2;

    logic [1:0]          st;
    logic [BW-1:0]       idx;
    logic [AW-1:0]       row, base;
    logic [PW-1:0]       px, py;
    logic                t_sob, t_eob, lx, ly, credit, wr, rd;
    logic [MEM_LAT-1:0]  pv, ps, pe;
    logic [PIX_W-1:0]    fd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fs, fe;
    logic [FW-1:0]       wp, rp;
    logic [CW-1:0]       cnt;
    logic [31:0]         infl;

    assign o_blk_rdy = st == IDLE;
    assign base = AW'(32'(idx) / COLUMNS * (BLK_SIZE * IMG_WIDTH) + 32'(idx) % COLUMNS * BLK_SIZE);
    assign lx = px == PW'(BLK_SIZE - 1);
    assign ly = py == PW'(BLK_SIZE - 1);
    assign wr = pv[MEM_LAT-1];
    assign o_pix_vld = cnt != '0;
    assign rd = o_pix_vld && i_pix_rdy;
    assign o_pix_data = o_pix_vld ? fd[rp] : '0;
    assign o_pix_sob = o_pix_vld && fs[rp];
    assign o_pix_eob = o_pix_vld && fe[rp];

    // Reads already issued but not yet in the FIFO count against the FIFO space.
    always_comb begin
        infl = 32'(o_mem_rd);
        for (int i = 0; i < MEM_LAT; i++) infl = infl + 32'(pv[i]);
    end
    assign credit = 32'(cnt) + infl < 32'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            idx <= '0;
            row <= '0;
            px <= '0;
            py <= '0;
            o_blk_err <= 1'b0;
            o_mem_rd <= 1'b0;
            o_mem_adr <= '0;
            t_sob <= 1'b0;
            t_eob <= 1'b0;
            pv <= '0;
            ps <= '0;
            pe <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            o_blk_err <= 1'b0;
            o_mem_rd <= 1'b0;
            o_mem_adr <= '0;
            t_sob <= 1'b0;
            t_eob <= 1'b0;
            pv[0] <= o_mem_rd;
            ps[0] <= t_sob;
            pe[0] <= t_eob;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
                pe[i] <= pe[i-1];
            end
            wp <= wp + FW'(wr);
            rp <= rp + FW'(rd);
            cnt <= cnt + CW'(wr) - CW'(rd);
            if (st == IDLE && i_blk_vld) begin
                if (32'(i_blk_adr) >= NBLK) o_blk_err <= 1'b1;
                else begin
                    idx <= i_blk_adr;
                    st <= CALC;
                end
            end
            if (st == CALC) begin
                row <= base;
                px <= '0;
                py <= '0;
                st <= FETCH;
            end
            if (st == FETCH && credit) begin
                o_mem_rd <= 1'b1;
                o_mem_adr <= row + AW'(px);
                t_sob <= px == '0 && py == '0;
                t_eob <= lx && ly;
                px <= lx ? '0 : px + 1'b1;
                if (lx) begin
                    py <= py + 1'b1;
                    row <= row + AW'(IMG_WIDTH);
                end
                if (lx && ly) st <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            fd[wp] <= i_mem_data;
            fs[wp] <= ps[MEM_LAT-1];
            fe[wp] <= pe[MEM_LAT-1];
        end
    end
endmodule

// File: tb/tb_blk_fetch.sv
// tb_blk_fetch: table-driven block fetch checks with a frame-buffer model and a
// pixel scoreboard, plus back-to-back and mid-block reset sequences.
module tb_blk_fetch;
    logic clk = 1'b0, rst = 1'b1, i_blk_vld = 1'b0, i_pix_rdy = 1'b1;
    logic [8:0] i_blk_adr = '0;
    logic o_blk_rdy, o_blk_err, o_mem_rd, o_pix_vld, o_pix_sob, o_pix_eob;
    logic [18:0] o_mem_adr;
    logic [7:0] i_mem_data, o_pix_data;
    logic [7:0] mp [2];

    always #5 clk = ~clk;

    blk_fetch dut (
        .clk(clk), .rst(rst), .i_blk_vld(i_blk_vld), .i_blk_adr(i_blk_adr),
        .o_blk_rdy(o_blk_rdy), .o_blk_err(o_blk_err), .o_mem_rd(o_mem_rd),
        .o_mem_adr(o_mem_adr), .i_mem_data(i_mem_data), .o_pix_vld(o_pix_vld),
        .o_pix_data(o_pix_data), .o_pix_sob(o_pix_sob), .o_pix_eob(o_pix_eob),
        .i_pix_rdy(i_pix_rdy)
    );

    function automatic logic [7:0] f(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'(a[18:16]);
    endfunction

    // Frame buffer: data for a read appears two cycles after its strobe.
    always @(posedge clk) begin
        mp[0] <= o_mem_rd ? f(o_mem_adr) : 8'h00;
        mp[1] <= mp[0];
    end
    assign i_mem_data = mp[1];

    typedef struct {int adr; logic s; logic e;} rd_t;
    typedef struct {logic [7:0] d; logic s; logic e;} px_t;
    typedef struct {int blk; bit rnd; bit err; int first; int last;} vec_t;
    rd_t aq[$];
    px_t pq[$];
    rd_t r;
    px_t p;
    int nc = 0, nf = 0, cyc = 0, issued = 0, popped = 0, acc = 0;
    int first_adr, last_adr, blk_pix, n_sob, n_eob, first_rd_cyc, first_vld_cyc, seams;
    bit prev_eob = 0, rnd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nc++;
        if (act != exp) begin
            nf++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_rd) begin
                issued++;
                if (first_adr < 0) first_adr = int'(o_mem_adr);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_adr = int'(o_mem_adr);
                if (aq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    r = aq.pop_front();
                    chk("mem_adr", o_mem_adr, r.adr);
                    pq.push_back('{f(19'(r.adr)), r.s, r.e});
                end
            end else chk("adr_idle_zero", o_mem_adr, 0);
            chk("credit_le_8", longint'(issued - popped > 8), 0);
            if (o_pix_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (o_pix_vld && i_pix_rdy) begin
                popped++;
                blk_pix++;
                n_sob += int'(o_pix_sob);
                n_eob += int'(o_pix_eob);
                if (prev_eob && o_pix_sob) seams++;
                prev_eob = o_pix_eob;
                if (pq.size() == 0) chk("pix_unexpected", 1, 0);
                else begin
                    p = pq.pop_front();
                    chk("pix_data", o_pix_data, p.d);
                    chk("pix_sob", o_pix_sob, p.s);
                    chk("pix_eob", o_pix_eob, p.e);
                end
            end
        end
        i_pix_rdy = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic arm;
        first_adr = -1;
        first_rd_cyc = -1;
        first_vld_cyc = -1;
        blk_pix = 0;
        n_sob = 0;
        n_eob = 0;
        seams = 0;
        prev_eob = 0;
    endtask

    task automatic gen(input int b);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                aq.push_back('{(b / 20 * 32 + y) * 640 + b % 20 * 32 + x, x == 0 && y == 0, x == 31 && y == 31});
    endtask

    task automatic send(input int b);
        int n = 0;
        if (b < 300) gen(b);
        i_blk_vld = 1'b1;
        i_blk_adr = 9'(b);
        while (!o_blk_rdy && n < 5000) begin
            step;
            n++;
        end
        if (n >= 5000) chk("rdy_timeout", 0, 1);
        step;
        acc = cyc;
        i_blk_vld = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((aq.size() != 0 || pq.size() != 0 || !o_blk_rdy || o_pix_vld) && n < 20000) begin
            step;
            n++;
        end
        if (n >= 20000) chk("drain_timeout", 0, 1);
    endtask

    vec_t tv[7];
    int iss0, n;

    initial begin
        tv[0] = '{0, 0, 0, 0, 19871};
        tv[1] = '{19, 0, 0, 608, 20479};
        tv[2] = '{20, 0, 0, 20480, 40351};
        tv[3] = '{299, 0, 0, 287328, 307199};
        tv[4] = '{300, 0, 1, 0, 0};
        tv[5] = '{511, 0, 1, 0, 0};
        tv[6] = '{5, 1, 0, 160, 20031};
        arm;
        repeat (3) step;
        chk("rst_blk_rdy", o_blk_rdy, 1);
        chk("rst_blk_err", o_blk_err, 0);
        chk("rst_mem_rd", o_mem_rd, 0);
        chk("rst_mem_adr", o_mem_adr, 0);
        chk("rst_pix_vld", o_pix_vld, 0);
        chk("rst_pix_data", o_pix_data, 0);
        rst = 1'b0;
        step;
        for (int i = 0; i < 7; i++) begin
            arm;
            rnd = tv[i].rnd;
            iss0 = issued;
            send(tv[i].blk);
            if (tv[i].err) begin
                chk("blk_err_pulse", o_blk_err, 1);
                chk("err_blk_rdy", o_blk_rdy, 1);
                step;
                chk("blk_err_1cyc", o_blk_err, 0);
                repeat (4) step;
                chk("err_no_reads", issued, iss0);
                chk("err_rdy_held", o_blk_rdy, 1);
            end else begin
                drain;
                chk("first_adr", first_adr, tv[i].first);
                chk("last_adr", last_adr, tv[i].last);
                chk("n_pix", blk_pix, 1024);
                chk("n_sob", n_sob, 1);
                chk("n_eob", n_eob, 1);
                chk("lat_rd", first_rd_cyc, acc + 2);
                chk("lat_vld", first_vld_cyc, acc + 5);
                chk("fsm_idle", o_blk_rdy, 1);
            end
        end
        rnd = 0;
        arm;
        send(19);
        send(20);
        drain;
        chk("b2b_first", first_adr, 608);
        chk("b2b_last", last_adr, 40351);
        chk("b2b_pix", blk_pix, 2048);
        chk("b2b_sob", n_sob, 2);
        chk("b2b_seam", seams, 1);
        arm;
        send(5);
        n = 0;
        while (blk_pix < 500 && n < 5000) begin
            step;
            n++;
        end
        if (n >= 5000) chk("pix500_timeout", 0, 1);
        rst = 1'b1;
        step;
        chk("mid_rst_pix_vld", o_pix_vld, 0);
        chk("mid_rst_mem_rd", o_mem_rd, 0);
        chk("mid_rst_blk_rdy", o_blk_rdy, 1);
        aq.delete();
        pq.delete();
        issued = 0;
        popped = 0;
        rst = 1'b0;
        step;
        arm;
        send(0);
        drain;
        chk("post_rst_first", first_adr, 0);
        chk("post_rst_last", last_adr, 19871);
        chk("post_rst_pix", blk_pix, 1024);
        chk("post_rst_lat", first_vld_cyc, acc + 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
